adc_i2s_deser_channel0: RTL and testbench

Serial-to-parallel stage for ADC channel 0. It sits directly downstream of the channel-0 SCLK bit counter and consumes its 6-bit frame position, `adc_sclk_cnt_channel0`. It shifts the I2S data line into 24-bit left/right words, presents each stereo pair with a one-cycle valid strobe, and monitors LRCK framing, reporting lock and frame errors.

---
 rtl/adc_i2s_deser_channel0.sv | 203 ++++++++++++++++++++
 tb/tb_adc_i2s_deser_channel0.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_i2s_deser_channel0.sv
// I2S deserializer for ADC channel 0: shifts left/right words keyed on the SCLK frame count and tracks LRCK lock.
// Optional saturating framing-error counter enabled by defining ADC_DESER_ERRCNT_EN.
module adc_i2s_deser_channel0 #(
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32
) (
  input  logic                adc_sclk_channel0,
  input  logic                adc_rst_channel0,
  input  logic                adc_lrck_channel0,
  input  logic                adc_sdata_channel0,
  input  logic [5:0]          adc_sclk_cnt_channel0,
  input  logic                err_clr,
  output logic [SAMPLE_W-1:0] left_data,
  output logic [SAMPLE_W-1:0] right_data,
  output logic                sample_valid,
  output logic                locked,
  output logic                frame_err,
  output logic [7:0]          err_cnt
);

  localparam logic [5:0] LEFT_LAST   = 6'(SAMPLE_W - 1);
  localparam logic [5:0] RIGHT_FIRST = 6'(SLOT_W);
  localparam logic [5:0] RIGHT_LAST  = 6'(SLOT_W + SAMPLE_W - 1);
  localparam logic [5:0] RISE_POS    = 6'(SLOT_W - 1);
  localparam logic [5:0] FALL_POS    = 6'(2 * SLOT_W - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SYNC     = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                seen_rise_r;
  logic                seen_rise_s;
  logic                been_locked_r;
  logic                lrck_d_r;
  logic [SAMPLE_W-1:0] left_sr_r;
  logic [SAMPLE_W-1:0] right_sr_r;
  logic                fall_s;
  logic                rise_s;
  logic                lock_err_s;
  logic                sync_err_s;
  logic                err_set_s;
  logic                complete_s;
  logic                in_left_s;
  logic                in_right_s;

  // Edge detection, lock qualification and per-frame framing checks.
  always_comb begin
    fall_s      = lrck_d_r & ~adc_lrck_channel0;
    rise_s      = ~lrck_d_r & adc_lrck_channel0;
    state_s     = state_r;
    seen_rise_s = seen_rise_r;
    lock_err_s  = 1'b0;
    sync_err_s  = 1'b0;
    case (state_r)
      ST_UNLOCKED: begin
        if (fall_s) begin
          state_s     = ST_SYNC;
          seen_rise_s = 1'b0;
        end else begin
          state_s = ST_UNLOCKED;
        end
      end
      ST_SYNC: begin
        if (rise_s) begin
          if (adc_sclk_cnt_channel0 == RISE_POS) begin
            seen_rise_s = 1'b1;
          end else begin
            sync_err_s  = 1'b1;
            seen_rise_s = 1'b0;
          end
        end else if (fall_s) begin
          seen_rise_s = 1'b0;
          if ((adc_sclk_cnt_channel0 == FALL_POS) && seen_rise_r) begin
            state_s = ST_LOCKED;
          end else begin
            sync_err_s = 1'b1;
          end
        end else if (adc_sclk_cnt_channel0 == FALL_POS) begin
          // End of frame reached without the closing fall: restart qualification.
          sync_err_s  = 1'b1;
          seen_rise_s = 1'b0;
        end else begin
          seen_rise_s = seen_rise_r;
        end
      end
      ST_LOCKED: begin
        if (rise_s && (adc_sclk_cnt_channel0 != RISE_POS)) begin
          lock_err_s = 1'b1;
        end else if (fall_s && (adc_sclk_cnt_channel0 != FALL_POS)) begin
          lock_err_s = 1'b1;
        end else if (!fall_s && (adc_sclk_cnt_channel0 == FALL_POS)) begin
          lock_err_s = 1'b1;
        end else begin
          lock_err_s = 1'b0;
        end
        if (lock_err_s) begin
          state_s     = ST_SYNC;
          seen_rise_s = 1'b0;
        end else begin
          state_s = ST_LOCKED;
        end
      end
      default: begin
        state_s     = ST_UNLOCKED;
        seen_rise_s = 1'b0;
      end
    endcase
    err_set_s  = lock_err_s | (sync_err_s & been_locked_r);
    complete_s = (state_r == ST_LOCKED) && (adc_sclk_cnt_channel0 == RIGHT_LAST) && !lock_err_s;
    in_left_s  = (adc_sclk_cnt_channel0 <= LEFT_LAST);
    in_right_s = (adc_sclk_cnt_channel0 >= RIGHT_FIRST) && (adc_sclk_cnt_channel0 <= RIGHT_LAST);
  end

  // State register and registered lock indication.
  always_ff @(posedge adc_sclk_channel0) begin
    if (adc_rst_channel0) begin
      state_r       <= ST_UNLOCKED;
      seen_rise_r   <= 1'b0;
      been_locked_r <= 1'b0;
      locked        <= 1'b0;
    end else begin
      state_r       <= state_s;
      seen_rise_r   <= seen_rise_s;
      been_locked_r <= been_locked_r | (state_r == ST_LOCKED);
      locked        <= (state_s == ST_LOCKED);
    end
  end

  // Shift registers, output words, valid strobe and sticky error flag.
  always_ff @(posedge adc_sclk_channel0) begin
    if (adc_rst_channel0) begin
      lrck_d_r     <= 1'b0;
      left_sr_r    <= {SAMPLE_W{1'b0}};
      right_sr_r   <= {SAMPLE_W{1'b0}};
      left_data    <= {SAMPLE_W{1'b0}};
      right_data   <= {SAMPLE_W{1'b0}};
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      lrck_d_r <= adc_lrck_channel0;
      // Any fall discards partially captured words.
      if (fall_s) begin
        left_sr_r  <= {SAMPLE_W{1'b0}};
        right_sr_r <= {SAMPLE_W{1'b0}};
      end else if (in_left_s) begin
        left_sr_r <= {left_sr_r[SAMPLE_W-2:0], adc_sdata_channel0};
      end else if (in_right_s) begin
        right_sr_r <= {right_sr_r[SAMPLE_W-2:0], adc_sdata_channel0};
      end else begin
        left_sr_r <= left_sr_r;
      end
      if (lock_err_s) begin
        left_data  <= {SAMPLE_W{1'b0}};
        right_data <= {SAMPLE_W{1'b0}};
      end else if (complete_s) begin
        left_data  <= left_sr_r;
        right_data <= {right_sr_r[SAMPLE_W-2:0], adc_sdata_channel0};
      end else begin
        left_data <= left_data;
      end
      sample_valid <= complete_s;
      if (err_set_s) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end else begin
        frame_err <= frame_err;
      end
    end
  end

`ifdef ADC_DESER_ERRCNT_EN
  logic [7:0] err_cnt_r;

  // Saturating count of errors seen while locked; a clear coinciding with an error leaves 1.
  always_ff @(posedge adc_sclk_channel0) begin
    if (adc_rst_channel0) begin
      err_cnt_r <= 8'd0;
    end else if (lock_err_s && err_clr) begin
      err_cnt_r <= 8'd1;
    end else if (lock_err_s) begin
      if (err_cnt_r != 8'd255) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end else if (err_clr) begin
      err_cnt_r <= 8'd0;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_adc_i2s_deser_channel0.sv
// Directed bench for adc_i2s_deser_channel0: the bench plays the bit-counter stage and drives
// whole 64-SCLK frames, checking words, valid timing, lock and framing-error behaviour.
module tb_adc_i2s_deser_channel0;

`ifdef ADC_DESER_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        lrck;
  logic        sdata;
  logic [5:0]  cnt;
  logic        clr;
  logic [23:0] left_data;
  logic [23:0] right_data;
  logic        sample_valid;
  logic        locked;
  logic        frame_err;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int vcount;
  int vpos;
  logic [23:0] snap_l;
  logic [23:0] snap_r;
  logic        snap_v;
  logic        snap_lk;
  logic        snap_fe;
  logic [7:0]  snap_cnt;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        pad;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  adc_i2s_deser_channel0 dut (
    .adc_sclk_channel0    (clk),
    .adc_rst_channel0     (rst),
    .adc_lrck_channel0    (lrck),
    .adc_sdata_channel0   (sdata),
    .adc_sclk_cnt_channel0(cnt),
    .err_clr              (clr),
    .left_data            (left_data),
    .right_data           (right_data),
    .sample_valid         (sample_valid),
    .locked               (locked),
    .frame_err            (frame_err),
    .err_cnt              (err_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step(input int pos, input logic lr, input logic sd, input logic cl, input logic rs);
    cnt   = 6'(pos % 64);
    lrck  = lr;
    sdata = sd;
    clr   = cl;
    rst   = rs;
    @(posedge clk);
    #1;
  endtask

  function automatic logic data_bit(input logic [23:0] l, input logic [23:0] r, input logic pad, input int pos);
    logic [4:0] idx;
    if (pos <= 23) begin
      idx = 5'(23 - pos);
      return l[idx];
    end else if (pos >= 32 && pos <= 55) begin
      idx = 5'(55 - pos);
      return r[idx];
    end else begin
      return pad;
    end
  endfunction

  // Drives positions first..last; LRCK high on 31..last-1, so the fall lands at position 'last'.
  task automatic frame(input logic [23:0] l, input logic [23:0] r, input logic pad, input int first,
                       input int last, input int probe, input logic clr_p, input logic rst_p);
    logic lr;
    vcount = 0;
    vpos   = -1;
    for (int p = first; p <= last; p++) begin
      lr = (p >= 31 && p < last);
      step(p, lr, data_bit(l, r, pad, p), (p == probe) ? clr_p : 1'b0, (p == probe) ? rst_p : 1'b0);
      if (sample_valid) begin
        vcount++;
        vpos = p + 1;
      end
      if (p == probe) begin
        snap_l   = left_data;
        snap_r   = right_data;
        snap_v   = sample_valid;
        snap_lk  = locked;
        snap_fe  = frame_err;
        snap_cnt = err_cnt;
      end
    end
  endtask

  task automatic clean(input logic [23:0] l, input logic [23:0] r);
    frame(l, r, 1'b0, 0, 63, -1, 1'b0, 1'b0);
  endtask

  task automatic valid_frame(input string nm, input logic [23:0] l, input logic [23:0] r);
    clean(l, r);
    chk({nm, "_vcount"}, 32'(vcount), 32'd1);
    chk({nm, "_vpos"}, 32'(vpos), 32'd56);
    chk({nm, "_left"}, 32'(left_data), 32'(l));
    chk({nm, "_right"}, 32'(right_data), 32'(r));
  endtask

  initial begin
    vecs[0] = '{l: 24'hA5A5A5, r: 24'h5A5A5A, pad: 1'b0, exp_l: 24'hA5A5A5, exp_r: 24'h5A5A5A};
    vecs[1] = '{l: 24'hA5A5A5, r: 24'h5A5A5A, pad: 1'b1, exp_l: 24'hA5A5A5, exp_r: 24'h5A5A5A};
    vecs[2] = '{l: 24'h123456, r: 24'hFEDCBA, pad: 1'b1, exp_l: 24'h123456, exp_r: 24'hFEDCBA};
    vecs[3] = '{l: 24'h000001, r: 24'h800000, pad: 1'b0, exp_l: 24'h000001, exp_r: 24'h800000};
    vecs[4] = '{l: 24'hFFFFFF, r: 24'h000000, pad: 1'b1, exp_l: 24'hFFFFFF, exp_r: 24'h000000};

    rst = 1'b1; lrck = 1'b0; sdata = 1'b0; cnt = 6'd0; clr = 1'b0;
    step(0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_left", 32'(left_data), 32'd0);
    chk("rst_right", 32'(right_data), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);

    // First fall only starts qualification; the second fall locks.
    clean(24'hA5A5A5, 24'h5A5A5A);
    chk("lock_after_fall1", 32'(locked), 32'd0);
    chk("valid_before_lock1", 32'(vcount), 32'd0);
    clean(24'hA5A5A5, 24'h5A5A5A);
    chk("lock_after_fall2", 32'(locked), 32'd1);
    chk("valid_before_lock2", 32'(vcount), 32'd0);

    for (int i = 0; i < 5; i++) begin
      frame(vecs[i].l, vecs[i].r, vecs[i].pad, 0, 63, -1, 1'b0, 1'b0);
      chk($sformatf("vec%0d_vcount", i), 32'(vcount), 32'd1);
      chk($sformatf("vec%0d_vpos", i), 32'(vpos), 32'd56);
      chk($sformatf("vec%0d_left", i), 32'(left_data), 32'(vecs[i].exp_l));
      chk($sformatf("vec%0d_right", i), 32'(right_data), 32'(vecs[i].exp_r));
      chk($sformatf("vec%0d_locked", i), 32'(locked), 32'd1);
      chk($sformatf("vec%0d_frame_err", i), 32'(frame_err), 32'd0);
    end

    // Short frame: fall at c=61 while locked.
    frame(24'h111111, 24'h222222, 1'b0, 0, 61, -1, 1'b0, 1'b0);
    chk("short_frame_err", 32'(frame_err), 32'd1);
    chk("short_locked", 32'(locked), 32'd0);
    chk("short_left", 32'(left_data), 32'd0);
    chk("short_right", 32'(right_data), 32'd0);
    chk("short_err_cnt", 32'(err_cnt), CNT_EN ? 32'd1 : 32'd0);
    clean(24'h333333, 24'h444444);
    chk("relock_vcount", 32'(vcount), 32'd0);
    chk("relock_locked", 32'(locked), 32'd1);

    // err_clr alone clears the flag (and the counter).
    frame(24'h0F0F0F, 24'hF0F0F0, 1'b0, 0, 63, 10, 1'b1, 1'b0);
    chk("clr_alone_fe", 32'(snap_fe), 32'd0);
    chk("clr_alone_cnt", 32'(snap_cnt), 32'd0);
    chk("clr_frame_vcount", 32'(vcount), 32'd1);
    chk("clr_frame_left", 32'(left_data), 32'h0F0F0F);

    // err_clr on the same edge as a new error: set wins.
    frame(24'h555555, 24'h666666, 1'b0, 0, 61, 61, 1'b1, 1'b0);
    chk("clr_with_err_fe", 32'(snap_fe), 32'd1);
    chk("clr_with_err_cnt", 32'(snap_cnt), CNT_EN ? 32'd1 : 32'd0);
    chk("clr_with_err_locked", 32'(locked), 32'd0);
    clean(24'h777777, 24'h888888);
    chk("relock2_locked", 32'(locked), 32'd1);
    frame(24'hABCDEF, 24'h012345, 1'b1, 0, 63, 0, 1'b1, 1'b0);
    chk("clr2_fe", 32'(snap_fe), 32'd0);
    chk("clr2_vcount", 32'(vcount), 32'd1);
    chk("clr2_right", 32'(right_data), 32'h012345);

    // LRCK stuck low for 70 SCLK after lock: error at c=63.
    for (int i = 0; i < 70; i++) begin
      step(i, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i == 62) begin
        chk("stuck_pre_locked", 32'(locked), 32'd1);
        chk("stuck_pre_fe", 32'(frame_err), 32'd0);
        chk("stuck_pre_left", 32'(left_data), 32'hFFFFFF);
      end
      if (i == 63) begin
        chk("stuck_fe", 32'(frame_err), 32'd1);
        chk("stuck_locked", 32'(locked), 32'd0);
        chk("stuck_left", 32'(left_data), 32'd0);
        chk("stuck_err_cnt", 32'(err_cnt), CNT_EN ? 32'd1 : 32'd0);
      end
    end
    frame(24'h0, 24'h0, 1'b0, 6, 63, -1, 1'b0, 1'b0);
    chk("stuck_relock", 32'(locked), 32'd1);
    valid_frame("post_stuck", 24'h135790, 24'h24680A);

    // Reset at c=40 of a locked frame.
    frame(24'hC3C3C3, 24'h3C3C3C, 1'b0, 0, 63, 40, 1'b0, 1'b1);
    chk("midrst_left", 32'(snap_l), 32'd0);
    chk("midrst_right", 32'(snap_r), 32'd0);
    chk("midrst_valid", 32'(snap_v), 32'd0);
    chk("midrst_locked", 32'(snap_lk), 32'd0);
    chk("midrst_fe", 32'(snap_fe), 32'd0);
    chk("midrst_err_cnt", 32'(snap_cnt), 32'd0);
    chk("midrst_vcount", 32'(vcount), 32'd0);
    chk("midrst_locked_end", 32'(locked), 32'd0);
    clean(24'h0, 24'h0);
    chk("rst_relock", 32'(locked), 32'd1);
    valid_frame("post_rst", 24'h5A5A5A, 24'hA5A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
